muldiv_seq: RTL and testbench



---
 rtl/rv32_pkg.sv | 23 ++
 rtl/adder_subtractor.sv | 26 ++
 rtl/muldiv_seq.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: M-extension funct3 codes and the muldiv sequencer states.
package rv32_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
   localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
   localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
   localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
   localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
   localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
   localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
   localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

   typedef enum logic [2:0] {
      MD_IDLE,
      MD_INIT,
      MD_ITER,
      MD_FIX,
      MD_DONE
   } muldiv_state_t;

endpackage

// File: rtl/adder_subtractor.sv
// Shared W-bit adder/subtractor: Cin=0 adds, Cin=1 subtracts (A + ~B + 1).
// Cout is the carry out of a zero-extended W+1 bit sum; in subtract mode it
// is 1 when no borrow occurred.
module adder_subtractor
   import rv32_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         Cin,
   output logic [W-1:0] S,
   output logic         Cout
);

   logic [W:0] sum;

   // Single carry chain; B is inverted and Cin injected for subtraction.
   always_comb begin
      sum = {1'b0, A} + {1'b0, (Cin ? ~B : B)} + {{W{1'b0}}, Cin};
   end

   assign S    = sum[W-1:0];
   assign Cout = sum[W];

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer. One operation at a time,
// 32 shift-add (multiply) or restoring shift-subtract (divide) iterations
// through one shared adder_subtractor, fixed 34-cycle latency.
module muldiv_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            kill_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   import rv32_pkg::*;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   muldiv_state_t state_q, state_d;

   logic [2:0]        op_q;
   logic [XLEN-1:0]   rs1_q, rs2_q;
   logic [XLEN-1:0]   opb_q;
   logic [XLEN-1:0]   hi_q, lo_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              neg1_q, neg2_q;

   logic              is_mul, sgn1, sgn2;
   logic [XLEN-1:0]   add_a, add_s;
   logic              add_cin, add_cout;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, fix_word;

   // Two's complement negation, kept off the shared adder.
   function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
      return '0 - v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
      return '0 - v;
   endfunction

   // Magnitude of an operand that is treated as signed.
   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? neg_w(v) : v;
   endfunction

   // Decode the latched funct3 into multiply/divide and operand signedness.
   always_comb begin
      is_mul = 1'b0;
      sgn1   = 1'b0;
      sgn2   = 1'b0;
      case (op_q)
         MULDIV_OP_MUL:    is_mul = 1'b1;
         MULDIV_OP_MULH:   begin is_mul = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
         MULDIV_OP_MULHSU: begin is_mul = 1'b1; sgn1 = 1'b1; end
         MULDIV_OP_MULHU:  is_mul = 1'b1;
         MULDIV_OP_DIV,
         MULDIV_OP_REM:    begin sgn1 = 1'b1; sgn2 = 1'b1; end
         MULDIV_OP_DIVU,
         MULDIV_OP_REMU:   ;
         default:          ;
      endcase
   end

   // Multiply adds mcand to hi; divide subtracts divisor from the shifted remainder.
   always_comb begin
      add_a   = is_mul ? hi_q : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
      add_cin = ~is_mul;
   end

   adder_subtractor #(.W(XLEN)) u_addsub (
      .A    (add_a),
      .B    (opb_q),
      .Cin  (add_cin),
      .S    (add_s),
      .Cout (add_cout)
   );

   // Sign fix-up, divide-by-zero override and result word selection.
   always_comb begin
      prod = {hi_q, lo_q};
      if (neg1_q ^ neg2_q) prod = neg_dw({hi_q, lo_q});
      quo = (neg1_q ^ neg2_q) ? neg_w(lo_q) : lo_q;
      rem = neg1_q ? neg_w(hi_q) : hi_q;
      if (rs2_q == '0) begin
         quo = '1;
         rem = rs1_q;
      end
      fix_word = '0;
      case (op_q)
         MULDIV_OP_MUL:    fix_word = prod[XLEN-1:0];
         MULDIV_OP_MULH,
         MULDIV_OP_MULHSU,
         MULDIV_OP_MULHU:  fix_word = prod[2*XLEN-1:XLEN];
         MULDIV_OP_DIV,
         MULDIV_OP_DIVU:   fix_word = quo;
         MULDIV_OP_REM,
         MULDIV_OP_REMU:   fix_word = rem;
         default:          fix_word = '0;
      endcase
   end

   // Next-state logic; a flush returns any active state to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (start_i && !kill_i) state_d = MD_INIT;
         MD_INIT: state_d = MD_ITER;
         MD_ITER: if (cnt_q == CNT_LAST) state_d = MD_FIX;
         MD_FIX:  state_d = MD_DONE;
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
      if (kill_i && state_q != MD_IDLE) state_d = MD_IDLE;
   end

   // State register and registered outputs, all derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MD_IDLE;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         result_o <= '0;
      end else begin
         state_q <= state_d;
         busy_o  <= (state_d != MD_IDLE);
         done_o  <= (state_d == MD_DONE);
         if (state_q == MD_FIX && state_d == MD_DONE) result_o <= fix_word;
      end
   end

   // Operand latch, sign recording and the 32-step iteration datapath.
   always_ff @(posedge clk) begin
      case (state_q)
         MD_IDLE: begin
            if (start_i) begin
               op_q  <= op_i;
               rs1_q <= rs1_i;
               rs2_q <= rs2_i;
            end
         end
         MD_INIT: begin
            neg1_q <= sgn1 & rs1_q[XLEN-1];
            neg2_q <= sgn2 & rs2_q[XLEN-1];
            hi_q   <= '0;
            cnt_q  <= '0;
            if (is_mul) begin
               opb_q <= mag(rs1_q, sgn1);
               lo_q  <= mag(rs2_q, sgn2);
            end else begin
               opb_q <= mag(rs2_q, sgn2);
               lo_q  <= mag(rs1_q, sgn1);
            end
         end
         MD_ITER: begin
            cnt_q <= cnt_q + CNT_ONE;
            if (is_mul) begin
               if (lo_q[0]) {hi_q, lo_q} <= {add_cout, add_s, lo_q[XLEN-1:1]};
               else         {hi_q, lo_q} <= {1'b0, hi_q, lo_q[XLEN-1:1]};
            end else begin
               // A remainder bit shifted out of hi guarantees the subtraction fits.
               if (add_cout || hi_q[XLEN-1]) begin
                  hi_q <= add_s;
                  lo_q <= {lo_q[XLEN-2:0], 1'b1};
               end else begin
                  hi_q <= add_a;
                  lo_q <= {lo_q[XLEN-2:0], 1'b0};
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and randomized bench for muldiv_seq against an arithmetic RV32M model.
module tb_muldiv_seq;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic        kill_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   int checks;
   int passed;

   muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .op_i     (op_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .kill_i   (kill_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, observed hang, required completion");
      $fatal(1, "watchdog");
   end

   // Reference RV32M semantics from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [63:0] sa, sb, ub_s, p;
      logic        [63:0] ua, ub, up;
      logic               ovf;
      sa   = {{32{a[31]}}, a};
      sb   = {{32{b[31]}}, b};
      ua   = {32'h0, a};
      ub   = {32'h0, b};
      ub_s = ub;
      ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: begin up = ua * ub;   return up[31:0];  end
         3'd1: begin p  = sa * sb;   return p[63:32];  end
         3'd2: begin p  = sa * ub_s; return p[63:32];  end
         3'd3: begin up = ua * ub;   return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            up = ua / ub; return up[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf)    return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            up = ua % ub; return up[31:0];
         end
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Issue one op from IDLE, then verify latency 34, the result and a single-cycle done.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      int          lat;
      logic [31:0] exp;
      exp     = ref_model(op, a, b);
      start_i = 1'b1;
      op_i    = op;
      rs1_i   = a;
      rs2_i   = b;
      @(posedge clk); #1;
      start_i = 1'b0;
      op_i    = 3'($urandom);
      rs1_i   = $urandom;
      rs2_i   = $urandom;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done_o) begin
            lat = k;
            break;
         end
      end
      check({tag, " latency"}, 64'(lat), 64'd34);
      check({tag, " result"}, 64'(result_o), 64'(exp));
      @(posedge clk); #1;
      check({tag, " done/busy after done"}, 64'({done_o, busy_o}), 64'd0);
   endtask

   initial begin
      int          dones;
      int          lat;
      logic [31:0] prev;
      logic [31:0] got;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      checks  = 0;
      passed  = 0;
      rst     = 1'b1;
      start_i = 1'b0;
      kill_i  = 1'b0;
      op_i    = 3'd0;
      rs1_i   = 32'h0;
      rs2_i   = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 64'(busy_o), 64'd0);
      check("reset done", 64'(done_o), 64'd0);
      check("reset result", 64'(result_o), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU ffff*ffff");
      run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MUL ffff*ffff");
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "MULH min*min");
      run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, "MULHSU -1*2");
      run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, "DIV -7/2");
      run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, "REM -7/2");
      run_op(3'd5, 32'd100, 32'd7, "DIVU 100/7");
      run_op(3'd7, 32'd100, 32'd7, "REMU 100/7");
      run_op(3'd5, 32'd5, 32'd0, "DIVU 5/0");
      run_op(3'd6, 32'd5, 32'd0, "REM 5/0");
      run_op(3'd4, 32'hFFFF_FFF9, 32'd0, "DIV -7/0");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV overflow");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM overflow");
      run_op(3'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "DIVU big divisor");

      // Flush a DIV in cycle 10, then start a MUL straight away.
      prev    = ref_model(3'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
      start_i = 1'b1;
      op_i    = 3'd4;
      rs1_i   = 32'd1000;
      rs2_i   = 32'd3;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      kill_i = 1'b1;
      @(posedge clk); #1;
      kill_i = 1'b0;
      check("kill busy", 64'(busy_o), 64'd0);
      check("kill done", 64'(done_o), 64'd0);
      check("kill result held", 64'(result_o), 64'(prev));
      run_op(3'd0, 32'd3, 32'd4, "MUL 3*4 after kill");

      // Start together with kill in IDLE is dropped.
      start_i = 1'b1;
      kill_i  = 1'b1;
      op_i    = 3'd0;
      rs1_i   = 32'd9;
      rs2_i   = 32'd9;
      @(posedge clk); #1;
      start_i = 1'b0;
      kill_i  = 1'b0;
      check("start+kill busy", 64'(busy_o), 64'd0);
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done_o) dones++;
      end
      check("start+kill no done", 64'(dones), 64'd0);

      // Reset in cycle 20 of a MUL discards it.
      start_i = 1'b1;
      op_i    = 3'd0;
      rs1_i   = 32'd7;
      rs2_i   = 32'd6;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midop reset busy", 64'(busy_o), 64'd0);
      check("midop reset done", 64'(done_o), 64'd0);
      check("midop reset result", 64'(result_o), 64'd0);
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done_o) dones++;
      end
      check("midop reset no done", 64'(dones), 64'd0);

      // A start pulse while busy is ignored: one done, original result.
      start_i = 1'b1;
      op_i    = 3'd0;
      rs1_i   = 32'd11;
      rs2_i   = 32'd13;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      start_i = 1'b1;
      op_i    = 3'd5;
      rs1_i   = 32'd50;
      rs2_i   = 32'd5;
      @(posedge clk); #1;
      start_i = 1'b0;
      dones = 0;
      lat   = -1;
      got   = 32'h0;
      for (int k = 6; k < 50; k++) begin
         @(posedge clk); #1;
         if (done_o) begin
            dones++;
            if (lat < 0) begin
               lat = k;
               got = result_o;
            end
         end
      end
      check("busy start done count", 64'(dones), 64'd1);
      check("busy start latency", 64'(lat), 64'd34);
      check("busy start result", 64'(got), 64'd143);

      // Randomized ops with corner operands mixed in.
      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0:       ra = 32'h0;
            1:       ra = 32'h8000_0000;
            2:       ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0:       rb = 32'h0;
            1:       rb = 32'h1;
            2:       rb = 32'hFFFF_FFFF;
            3:       rb = 32'($urandom_range(1, 255));
            default: rb = $urandom;
         endcase
         run_op(rop, ra, rb, $sformatf("rand%0d op%0d a=%h b=%h", i, rop, ra, rb));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
